// File: rtl/digit_scanner.sv
// ---------------------------------------------------------------------------
// digit_scanner
//
// Time-multiplexed driver for a multi-digit display. One digit is lit at a
// time. A three-level counter chain paces the scan:
//   tick counter (0..DIV-1) -> sub counter (0..15) -> slot index.
// The sub counter doubles as the PWM phase that sets brightness. New digit
// codes are staged and only copied into the displayed (shadow) register at a
// frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   digits_in   packed digit codes; digit 0 sits in the low DIGIT_W bits
//   load        capture digits_in (applied at the next frame boundary)
//   enable      1 = scan, 0 = display off
//   blank_lz    suppress leading zero digits (digit 0 always shown)
//   brightness  PWM duty code, duty = (brightness+1)/16
//   digitout    registered code of the active digit
//   cs          registered digit selects, at most one active
//   frame_done  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module digit_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 4,
   parameter int DIV        = 3125,
   parameter bit CS_ACTIVE  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic                          load,
   input  logic                          enable,
   input  logic                          blank_lz,
   input  logic [3:0]                    brightness,
   output logic [DIGIT_W-1:0]            digitout,
   output logic [NUM_DIGITS-1:0]         cs,
   output logic                          frame_done
);

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW = $clog2(NUM_DIGITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

   typedef enum logic {OFF, SCAN} state_t;

   state_t state;
   state_t next_state;

   logic [TW-1:0] tick;
   logic [3:0]    sub;
   logic [SW-1:0] slot;

   logic [NUM_DIGITS*DIGIT_W-1:0] staging;
   logic [NUM_DIGITS*DIGIT_W-1:0] shadow;
   logic                          pending;

   logic [DIGIT_W-1:0]    dig [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] supp;
   logic                  higher_zero;
   logic [NUM_DIGITS-1:0] cs_next;

   logic scanning;
   logic tick_end;
   logic sub_end;
   logic slot_end;
   logic wrap;
   logic lit;

   // State register: the display is either dark or scanning.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OFF;
      end else begin
         state <= next_state;
      end
   end

   // Next state follows enable directly; leaving SCAN takes effect at the
   // same edge that samples enable low.
   always_comb begin
      next_state = state;
      if (enable) begin
         next_state = SCAN;
      end else begin
         next_state = OFF;
      end
   end

   // Scanning requires both the registered state and the live enable, so
   // the selects go dark on the very edge that sees enable drop. The wrap
   // strobe marks the final cycle of the last slot in a frame.
   always_comb begin
      scanning = (state == SCAN) && enable;
      tick_end = (tick == TICK_LAST);
      sub_end  = tick_end && (sub == 4'hF);
      slot_end = (slot == SLOT_LAST);
      wrap     = scanning && sub_end && slot_end;
   end

   // Counter chain. Anything other than active scanning parks all counters
   // at zero so a restart always begins at slot 0, sub 0.
   always_ff @(posedge clk) begin
      if (rst || !scanning) begin
         tick <= '0;
         sub  <= '0;
         slot <= '0;
      end else begin
         if (tick_end) begin
            tick <= '0;
            sub  <= sub + 4'd1;
         end else begin
            tick <= tick + TW'(1);
         end
         if (sub_end) begin
            slot <= slot_end ? '0 : slot + SW'(1);
         end
      end
   end

   // Double-buffered digit storage. Loads land in staging; staging moves to
   // shadow only at a frame boundary or while the display is off. A load on
   // the boundary cycle itself bypasses staging and is displayed next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         staging <= '0;
         shadow  <= '0;
         pending <= 1'b0;
      end else if ((state == OFF) || wrap) begin
         if (load) begin
            staging <= digits_in;
            shadow  <= digits_in;
         end else if (pending) begin
            shadow  <= staging;
         end
         pending <= 1'b0;
      end else if (load) begin
         staging <= digits_in;
         pending <= 1'b1;
      end
   end

   // Unpack the shadow register and work out which digits are leading
   // zeros, scanning from the most significant digit downwards.
   always_comb begin
      higher_zero = 1'b1;
      supp        = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         dig[i]      = shadow[i*DIGIT_W +: DIGIT_W];
         higher_zero = higher_zero && (dig[i] == '0);
         supp[i]     = blank_lz && higher_zero && (i != 0);
      end
   end

   // Lit decision and the select pattern for the current slot.
   always_comb begin
      lit     = scanning && (sub <= brightness) && !supp[slot];
      cs_next = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cs_next[i] = (lit && (slot == SW'(i))) ? CS_ACTIVE : ~CS_ACTIVE;
      end
   end

   // Output register: one clock behind the counters, glitch-free selects.
   always_ff @(posedge clk) begin
      if (rst) begin
         digitout   <= '0;
         cs         <= {NUM_DIGITS{~CS_ACTIVE}};
         frame_done <= 1'b0;
      end else begin
         digitout   <= dig[slot];
         cs         <= cs_next;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_digit_scanner.sv
// ---------------------------------------------------------------------------
// tb_digit_scanner
//
// Drives digit_scanner (4 digits, 4-bit codes, DIV=2, active-high selects)
// through directed scenarios and a randomized run, comparing every cycle
// against a behavioural model that derives slot and PWM phase from a single
// elapsed-clock count.
// ---------------------------------------------------------------------------
module tb_digit_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits_in;
   logic        load;
   logic        enable;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic [3:0]  digitout;
   logic [3:0]  cs;
   logic        frame_done;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Behavioural model state
   bit          m_on;
   int          m_phase;
   logic [15:0] m_shadow;
   logic [15:0] m_staging;
   bit          m_pending;
   logic [3:0]  exp_dig;
   logic [3:0]  exp_cs;
   logic        exp_fd;

   // Held values for idle cycles
   bit          cur_en;
   bit          cur_blz;
   logic [3:0]  cur_bri;
   logic [15:0] cur_din;

   digit_scanner #(
      .NUM_DIGITS(4),
      .DIGIT_W(4),
      .DIV(2),
      .CS_ACTIVE(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .digits_in(digits_in),
      .load(load),
      .enable(enable),
      .blank_lz(blank_lz),
      .brightness(brightness),
      .digitout(digitout),
      .cs(cs),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] nib(input logic [15:0] v, input int idx);
      logic [15:0] s;
      s = v >> (4 * idx);
      return s[3:0];
   endfunction

   // Drive one cycle of inputs at the falling edge, advance the model for
   // the rising edge, then leave time for outputs to settle.
   task automatic applyStimulus(input bit r, input bit ld, input bit en,
                                input bit blz, input logic [3:0] bri,
                                input logic [15:0] din);
      int  slot;
      int  sub;
      bit  scanning;
      bit  wrap;
      bit  supp;
      @(negedge clk);
      rst        = r;
      load       = ld;
      enable     = en;
      blank_lz   = blz;
      brightness = bri;
      digits_in  = din;
      @(posedge clk);
      if (r) begin
         exp_dig   = 4'h0;
         exp_cs    = 4'b0000;
         exp_fd    = 1'b0;
         m_on      = 1'b0;
         m_phase   = 0;
         m_shadow  = 16'h0;
         m_staging = 16'h0;
         m_pending = 1'b0;
      end else begin
         slot     = (m_phase / 32) % 4;
         sub      = (m_phase / 2) % 16;
         scanning = m_on && en;
         wrap     = scanning && ((m_phase % 128) == 127);
         supp     = blz && (slot >= 1) && ((m_shadow >> (4 * slot)) == 16'h0);
         exp_dig  = nib(m_shadow, slot);
         exp_cs   = (scanning && (sub <= int'(bri)) && !supp) ? 4'(1 << slot) : 4'b0000;
         exp_fd   = wrap;
         if (!m_on || wrap) begin
            if (ld) begin
               m_staging = din;
               m_shadow  = din;
            end else if (m_pending) begin
               m_shadow  = m_staging;
            end
            m_pending = 1'b0;
         end else if (ld) begin
            m_staging = din;
            m_pending = 1'b1;
         end
         m_phase = scanning ? m_phase + 1 : 0;
         m_on    = en;
      end
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1, 0, 0, 0, 4'hF, 16'h0);
      applyStimulus(1, 1, 1, 0, 4'hF, 16'hFFFF);
      checks++;
      if (cs !== 4'b0000 || digitout !== 4'h0 || frame_done !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset: cs=%b digitout=%h fd=%b, required cs=0000 digitout=0 fd=0",
                  cs, digitout, frame_done);
      end else passes++;
   endtask

   task automatic test_scan();
      int fd_count = 0;
      cur_en = 1; cur_blz = 0; cur_bri = 4'hF; cur_din = 16'h1234;
      applyStimulus(0, 1, 0, 0, 4'hF, 16'h1234);
      for (int c = 0; c < 260; c++) begin
         applyStimulus(0, 0, 1, 0, 4'hF, 16'h1234);
         if (frame_done === 1'b1) fd_count++;
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL scan c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
      checks++;
      if (fd_count !== 2) begin
         fails++;
         $display("[TB] FAIL frame_done_count: got %0d, required 2", fd_count);
      end else passes++;
   endtask

   task automatic test_brightness();
      int highs [4] = '{0, 0, 0, 0};
      cur_bri = 4'd3;
      for (int c = 0; c < 128; c++) begin
         applyStimulus(0, 0, 1, 0, 4'd3, cur_din);
         for (int b = 0; b < 4; b++) if (cs[b] === 1'b1) highs[b]++;
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL bright c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (highs[b] !== 8) begin
            fails++;
            $display("[TB] FAIL duty cs[%0d]: high %0d cycles, required 8", b, highs[b]);
         end else passes++;
      end
      cur_bri = 4'hF;
   endtask

   task automatic test_blank();
      int low_highs = 0;
      int d0_highs  = 0;
      int all_highs [4] = '{0, 0, 0, 0};
      cur_blz = 1; cur_din = 16'h0007;
      applyStimulus(0, 1, 1, 1, 4'hF, 16'h0007);
      for (int c = 0; c < 258; c++) begin
         applyStimulus(0, 0, 1, 1, 4'hF, 16'h0007);
         if (c >= 130) begin
            if (cs[3:1] !== 3'b000) low_highs++;
            if (cs[0] === 1'b1 && digitout === 4'h7) d0_highs++;
         end
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL blank c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
      checks++;
      if (low_highs !== 0 || d0_highs !== 32) begin
         fails++;
         $display("[TB] FAIL blank_sel: upper-select cycles=%0d digit0 cycles=%0d, required 0 and 32",
                  low_highs, d0_highs);
      end else passes++;
      cur_blz = 0;
      for (int c = 0; c < 128; c++) begin
         applyStimulus(0, 0, 1, 0, 4'hF, 16'h0007);
         for (int b = 0; b < 4; b++) if (cs[b] === 1'b1) all_highs[b]++;
      end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (all_highs[b] !== 32) begin
            fails++;
            $display("[TB] FAIL noblank cs[%0d]: high %0d cycles, required 32", b, all_highs[b]);
         end else passes++;
      end
   endtask

   task automatic test_tearing();
      int guard = 0;
      cur_din = 16'h1234;
      applyStimulus(0, 1, 1, 0, 4'hF, 16'h1234);
      for (int c = 0; c < 140; c++) applyStimulus(0, 0, 1, 0, 4'hF, 16'h1234);
      // Load mid-slot 1; the rest of the frame must still show 0x1234
      while (!(m_on && (m_phase % 128) == 40) && guard < 200) begin
         applyStimulus(0, 0, 1, 0, 4'hF, 16'h1234);
         guard++;
      end
      applyStimulus(0, 1, 1, 0, 4'hF, 16'h5678);
      for (int c = 0; c < 150; c++) begin
         applyStimulus(0, 0, 1, 0, 4'hF, 16'h5678);
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL tear c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
      // Load exactly on the wrap cycle
      guard = 0;
      while (!(m_on && (m_phase % 128) == 127) && guard < 200) begin
         applyStimulus(0, 0, 1, 0, 4'hF, 16'h5678);
         guard++;
      end
      checks++;
      if (guard >= 200) begin
         fails++;
         $display("[TB] FAIL wrap_wait: timed out after %0d cycles, required < 200", guard);
      end else passes++;
      applyStimulus(0, 1, 1, 0, 4'hF, 16'h9ABC);
      applyStimulus(0, 0, 1, 0, 4'hF, 16'h9ABC);
      checks++;
      if (digitout !== 4'hC || cs !== 4'b0001) begin
         fails++;
         $display("[TB] FAIL wrap_load: dig=%h cs=%b, required dig=c cs=0001", digitout, cs);
      end else passes++;
      cur_din = 16'h9ABC;
   endtask

   task automatic test_enable();
      int guard = 0;
      while (!(m_on && (m_phase % 128) == 80) && guard < 200) begin
         applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
         guard++;
      end
      applyStimulus(0, 0, 0, 0, 4'hF, cur_din);
      checks++;
      if (cs !== 4'b0000 || frame_done !== 1'b0) begin
         fails++;
         $display("[TB] FAIL disable: cs=%b fd=%b, required cs=0000 fd=0", cs, frame_done);
      end else passes++;
      for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, 4'hF, cur_din);
      applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
      applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
      checks++;
      if (cs !== 4'b0001 || digitout !== nib(cur_din, 0)) begin
         fails++;
         $display("[TB] FAIL restart: cs=%b dig=%h, required cs=0001 dig=%h",
                  cs, digitout, nib(cur_din, 0));
      end else passes++;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL reenable c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while (!(m_on && (m_phase % 128) == 112) && guard < 200) begin
         applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
         guard++;
      end
      applyStimulus(1, 1, 1, 0, 4'hF, cur_din);
      checks++;
      if (cs !== 4'b0000 || digitout !== 4'h0 || frame_done !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mid_reset: cs=%b dig=%h fd=%b, required cs=0000 dig=0 fd=0",
                  cs, digitout, frame_done);
      end else passes++;
      applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
      applyStimulus(0, 0, 1, 0, 4'hF, cur_din);
      checks++;
      if (cs !== 4'b0001 || digitout !== 4'h0) begin
         fails++;
         $display("[TB] FAIL post_reset: cs=%b dig=%h, required cs=0001 dig=0", cs, digitout);
      end else passes++;
   endtask

   task automatic test_random();
      bit          r;
      bit          ld;
      logic [15:0] din;
      for (int c = 0; c < 1500; c++) begin
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 99) == 0) cur_en  = ~cur_en;
         if ($urandom_range(0, 59) == 0) cur_blz = ~cur_blz;
         if ($urandom_range(0, 49) == 0) cur_bri = 4'($urandom_range(0, 15));
         din = 16'($urandom);
         if ($urandom_range(0, 1) == 0) din[15:8] = 8'h00;
         applyStimulus(r, ld, cur_en, cur_blz, cur_bri, din);
         checks++;
         if (digitout !== exp_dig || cs !== exp_cs || frame_done !== exp_fd) begin
            fails++;
            $display("[TB] FAIL random c%0d: dig=%h cs=%b fd=%b, required dig=%h cs=%b fd=%b",
                     c, digitout, cs, frame_done, exp_dig, exp_cs, exp_fd);
         end else passes++;
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; enable = 1'b0; blank_lz = 1'b0;
      brightness = 4'hF; digits_in = 16'h0;
      test_reset();
      test_scan();
      test_brightness();
      test_blank();
      test_tearing();
      test_enable();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of scanned digits (legal 2..8).
REQ-002 Parameter DIGIT_W, default 4, bits per digit code.
REQ-003 Parameter DIV, default 3125, clocks per brightness tick (legal >= 1); one digit slot = 16 ticks.
REQ-004 Parameter CS_ACTIVE, default 1, active level of every cs bit.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 digits_in  in  NUM_DIGITS*DIGIT_W  digit codes; digit i = bits [i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
REQ-008 load  in  1  request to capture digits_in into the shadow register.
REQ-009 enable  in  1  1 = scan, 0 = display off.
REQ-010 blank_lz  in  1  leading-zero suppression enable.
REQ-011 brightness  in  4  PWM duty code.
REQ-012 digitout  out  DIGIT_W  registered code of the active digit.
REQ-013 cs  out  NUM_DIGITS  registered one-hot-or-zero digit selects.
REQ-014 frame_done  out  1  registered one-cycle pulse at frame end.

Function
REQ-015 Counters: tick counter 0..DIV-1; sub counter 0..15, advancing on tick-counter terminal; slot index 0..NUM_DIGITS-1, advancing when sub=15 and tick terminal; slot wraps NUM_DIGITS-1 -> 0.
REQ-016 States: OFF (enable=0) and SCAN (enable=1); OFF holds all counters at 0 and drives every cs inactive; OFF -> SCAN on enable=1; SCAN -> OFF on enable=0, taking effect at the next edge.
REQ-017 Shadow register: load=1 sets a pending flag and latches digits_in into a staging register; staging is copied to the shadow register at the slot wrap (frame boundary), or immediately when OFF; this prevents mid-frame tearing.
REQ-018 load coincident with the wrap cycle: the new digits_in reaches the shadow register in that same edge; a second load before the boundary overwrites staging (last wins).
REQ-019 Output register: each edge, digitout <= shadow digit[slot]; cs[slot] <= CS_ACTIVE when lit, all other cs bits <= ~CS_ACTIVE; latency 1 clock from counters to outputs.
REQ-020 Lit condition: state SCAN, sub <= brightness (duty (brightness+1)/16; brightness 15 = full on), and not suppressed.
REQ-021 Suppression: with blank_lz=1, digit i (i >= 1) is suppressed when it and every higher digit equal 0; digit 0 is never suppressed; digitout still carries the code.
REQ-022 brightness and blank_lz are sampled every cycle; changes take effect within one clock.
REQ-023 frame_done = 1 for exactly one cycle, on the edge after the slot wrap; never asserted in OFF.
REQ-024 At most one cs bit is active in any cycle; slot change produces no overlap cycle.

Reset
REQ-025 rst=1 at any edge, including mid-frame: counters, slot, pending flag, staging and shadow <= 0; digitout <= 0; cs <= all ~CS_ACTIVE; frame_done <= 0; state <= OFF.
REQ-026 rst has priority over load and enable; the first slot after release starts at slot 0, sub 0.

Verification (NUM_DIGITS=4, DIGIT_W=4, DIV=2, CS_ACTIVE=1; slot = 32 clocks, frame = 128)
REQ-027 Reset, then load 0x1234 while OFF, enable=1, brightness=15 -> cs sequence 0001,0010,0100,1000 for 32 clocks each; digitout 4,3,2,1; frame_done pulse every 128 clocks.
REQ-028 brightness=3 -> each cs bit high 8 of 32 clocks (sub 0..3), low for the remaining 24; digitout unchanged.
REQ-029 Load 0x0007 with blank_lz=1 -> only cs[0] ever asserts, digitout=7 in slot 0; blank_lz=0 -> all four selects scan, digitout 0 in slots 1..3.
REQ-030 Load 0x5678 during slot 1 -> outputs keep 0x1234 values until the frame wrap, then slot 0 shows 8; load on the wrap cycle -> new value in slot 0 of the next frame.
REQ-031 enable=0 mid-slot 2 -> cs=0000 on the next edge, no frame_done; enable=1 again -> scan restarts at slot 0, sub 0.
REQ-032 rst pulsed mid-slot 3 -> next edge cs=0000, digitout=0, shadow=0; after release with enable=1, slot 0 shows 0.
